// File: rtl/dft_loopback_jig.sv
// -----------------------------------------------------------------------------
// dft_loopback_jig
//
// Jig-side controller for the board I/O loopback self-test. The device under
// test copies every stimulus pin to a paired response pin and outputs a
// divided clock on its SCK pin. One run of this block:
//   1. drives all stimulus pins high and compares the looped-back response,
//   2. walks a single zero across the stimulus pins, comparing after each step
//      (catches opens, stuck pins and pin-to-pin shorts),
//   3. measures one half period of the DUT divided clock to prove the DUT
//      clock tree and PLL are alive,
//   4. parks in DONE with registered pass/fail results.
//
// Ports
//   clk_48mhz      jig clock
//   rst_n          synchronous active-low reset; aborts any run
//   start          one-cycle pulse, accepted in IDLE or DONE only
//   stim           drives the DUT input pins
//   resp           DUT output pins (asynchronous, synchronized here)
//   dut_sck        DUT divided clock (asynchronous, synchronized here)
//   busy           high while a run is in progress
//   done           high from the end of a run until the next accepted start
//   pass           valid while done: no pin mismatch and clock in tolerance
//   fail_mask      sticky per-pin mismatch flags
//   clk_ok         measured half period within EXPECT_HALF +/- TOL
//   measured_half  last measured half period in clk_48mhz cycles (0 on timeout)
// -----------------------------------------------------------------------------
module dft_loopback_jig #(
  parameter int N_PINS        = 20,
  parameter int SETTLE_CYCLES = 48,       // must be >= 3
  parameter int EXPECT_HALF   = 1000001,
  parameter int TOL           = 1000,
  parameter int CNT_W         = 22        // must hold 2*EXPECT_HALF
) (
  input  logic              clk_48mhz,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_PINS-1:0] stim,
  input  logic [N_PINS-1:0] resp,
  input  logic              dut_sck,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_PINS-1:0] fail_mask,
  output logic              clk_ok,
  output logic [CNT_W-1:0]  measured_half
);

  localparam int IDX_W    = (N_PINS > 1) ? $clog2(N_PINS) : 1;
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(N_PINS - 1);
  localparam logic [CNT_W-1:0]    TIMEOUT     = CNT_W'(2 * EXPECT_HALF);
  localparam logic [CNT_W:0]      HALF_LO     = (CNT_W+1)'(EXPECT_HALF - TOL);
  localparam logic [CNT_W:0]      HALF_HI     = (CNT_W+1)'(EXPECT_HALF + TOL);
  localparam logic [N_PINS-1:0]   BIT0        = N_PINS'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALL_HIGH,
    S_WALK,
    S_SCK_WAIT,
    S_SCK_MEAS,
    S_DONE
  } state_t;

  state_t              state;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    cnt;

  // Two-flop synchronizers for the asynchronous DUT pins, plus one extra
  // flop on sck so either edge can be detected in the jig clock domain.
  logic [N_PINS-1:0] resp_meta;
  logic [N_PINS-1:0] resp_sync;
  logic              sck_meta;
  logic              sck_sync;
  logic              sck_prev;

  // NOTE: every clocked state element uses non-blocking assignment so all
  // flops update together at the edge regardless of statement order.
  always_ff @(posedge clk_48mhz) begin
    if (!rst_n) begin
      resp_meta <= '0;
      resp_sync <= '0;
      sck_meta  <= 1'b0;
      sck_sync  <= 1'b0;
      sck_prev  <= 1'b0;
    end else begin
      resp_meta <= resp;
      resp_sync <= resp_meta;
      sck_meta  <= dut_sck;
      sck_sync  <= sck_meta;
      sck_prev  <= sck_sync;
    end
  end

  logic              sck_edge;
  logic              settle_done;
  logic [IDX_W-1:0]  idx_next;
  logic [CNT_W:0]    meas;
  logic              in_tol;

  assign sck_edge    = sck_sync ^ sck_prev;
  assign settle_done = (settle_cnt == SETTLE_LAST);
  assign idx_next    = idx + IDX_W'(1);
  // The counter restarts at 0 on the cycle after the first edge, so the
  // number of cycles between the two edges is count + 1 on the second edge.
  assign meas        = {1'b0, cnt} + (CNT_W+1)'(1);
  assign in_tol      = (meas >= HALF_LO) && (meas <= HALF_HI);

  always_ff @(posedge clk_48mhz) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      stim          <= '1;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      clk_ok        <= 1'b0;
      fail_mask     <= '0;
      measured_half <= '0;
      settle_cnt    <= '0;
      idx           <= '0;
      cnt           <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_ALL_HIGH;
            stim          <= '1;
            busy          <= 1'b1;
            done          <= 1'b0;
            pass          <= 1'b0;
            clk_ok        <= 1'b0;
            fail_mask     <= '0;
            measured_half <= '0;
            settle_cnt    <= '0;
            idx           <= '0;
          end
        end

        S_ALL_HIGH: begin
          if (settle_done) begin
            fail_mask  <= fail_mask | (stim ^ resp_sync);
            settle_cnt <= '0;
            idx        <= '0;
            stim       <= ~BIT0;
            state      <= S_WALK;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        S_WALK: begin
          if (settle_done) begin
            // A short pulls the neighbour low with the walking zero, so the
            // neighbour's bit mismatches here; the partner is flagged on its
            // own step.
            fail_mask  <= fail_mask | (stim ^ resp_sync);
            settle_cnt <= '0;
            if (idx == IDX_LAST) begin
              stim  <= '1;
              cnt   <= '0;
              state <= S_SCK_WAIT;
            end else begin
              idx  <= idx_next;
              stim <= ~(BIT0 << idx_next);
            end
          end else begin
            settle_cnt <= settle_cnt + SETTLE_W'(1);
          end
        end

        S_SCK_WAIT: begin
          if (cnt == TIMEOUT) begin
            measured_half <= '0;
            clk_ok        <= 1'b0;
            pass          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= S_DONE;
          end else if (sck_edge) begin
            cnt   <= '0;
            state <= S_SCK_MEAS;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_SCK_MEAS: begin
          // Timeout takes priority so the reported half period always fits
          // in CNT_W bits.
          if (cnt == TIMEOUT) begin
            measured_half <= '0;
            clk_ok        <= 1'b0;
            pass          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= S_DONE;
          end else if (sck_edge) begin
            measured_half <= meas[CNT_W-1:0];
            clk_ok        <= in_tol;
            pass          <= (fail_mask == '0) && in_tol;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          stim  <= '1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dft_loopback_jig.sv
// -----------------------------------------------------------------------------
// tb_dft_loopback_jig
//
// Bench for dft_loopback_jig with N_PINS=4, SETTLE_CYCLES=8, EXPECT_HALF=100,
// TOL=2, CNT_W=10. A board model loops stim back to resp with optional
// stuck-at-0 or wired-AND faults, and a free-running generator produces
// dut_sck with a programmable half period. Expected results are derived from
// the test rules: every applied pattern XOR its faulted response, and the
// generated half period against the tolerance window.
// -----------------------------------------------------------------------------
module tb_dft_loopback_jig;

  localparam int N   = 4;
  localparam int S   = 8;
  localparam int EH  = 100;
  localparam int TOL = 2;
  localparam int CW  = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  stim;
  logic [N-1:0]  resp;
  logic          dut_sck;
  logic          busy;
  logic          done;
  logic          pass;
  logic [N-1:0]  fail_mask;
  logic          clk_ok;
  logic [CW-1:0] measured_half;

  int checks   = 0;
  int failures = 0;

  // Board fault model: 0 ideal, 1 pin fault_a stuck at 0,
  // 2 pins fault_a and fault_b wired-AND shorted.
  int fault_mode = 0;
  int fault_a    = 0;
  int fault_b    = 1;

  int sck_half = EH;
  bit sck_run  = 1'b0;

  logic [N-1:0] seq[$];
  logic         snap_busy;
  logic         snap_done;
  logic [N-1:0] snap_mask;
  logic [CW-1:0] snap_meas;
  logic         snap_ok;

  always #5 clk = ~clk;

  dft_loopback_jig #(
    .N_PINS(N), .SETTLE_CYCLES(S), .EXPECT_HALF(EH), .TOL(TOL), .CNT_W(CW)
  ) dut (
    .clk_48mhz    (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stim         (stim),
    .resp         (resp),
    .dut_sck      (dut_sck),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .fail_mask    (fail_mask),
    .clk_ok       (clk_ok),
    .measured_half(measured_half)
  );

  function automatic logic [N-1:0] board(input logic [N-1:0] s, input int mode,
                                         input int a, input int b);
    logic [N-1:0] r;
    r = s;
    if (mode == 1) begin
      r[a] = 1'b0;
    end else if (mode == 2) begin
      r[a] = s[a] & s[b];
      r[b] = s[a] & s[b];
    end
    return r;
  endfunction

  assign resp = board(stim, fault_mode, fault_a, fault_b);

  // dut_sck generator: toggles every sck_half clocks while sck_run is set.
  initial begin
    int c;
    c = 0;
    dut_sck = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!sck_run) begin
        c = 0;
      end else begin
        c++;
        if (c >= sck_half) begin
          c = 0;
          dut_sck = ~dut_sck;
        end
      end
    end
  end

  // Patterns applied by a run: all ones, then a zero walking from bit 0 up.
  function automatic logic [N-1:0] walk_pattern(input int i);
    logic [N-1:0] p;
    p = '1;
    p[i] = 1'b0;
    return p;
  endfunction

  function automatic logic [N-1:0] exp_mask(input int mode, input int a, input int b);
    logic [N-1:0] m;
    logic [N-1:0] all_ones;
    all_ones = '1;
    m = all_ones ^ board(all_ones, mode, a, b);
    for (int i = 0; i < N; i++) m |= walk_pattern(i) ^ board(walk_pattern(i), mode, a, b);
    return m;
  endfunction

  function automatic bit exp_clk_ok(input int h);
    int d;
    d = h - EH;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  // Stim history must be 1..1, each walking pattern in order, then 1..1.
  function automatic bit seq_ok();
    logic [N-1:0] e[$];
    e.push_back('1);
    for (int i = 0; i < N; i++) e.push_back(walk_pattern(i));
    e.push_back('1);
    if (seq.size() != e.size()) return 1'b0;
    for (int i = 0; i < e.size(); i++) if (seq[i] !== e[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Pulses start, snapshots outputs right after acceptance, records every
  // distinct stim value, and waits (bounded) for done. mid_start_at >= 0
  // pulses start again that many cycles into the run.
  task automatic run_once(input int mid_start_at, output int cycles, output bit timed_out);
    logic [N-1:0] last;
    seq.delete();
    last = stim;
    seq.push_back(stim);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    snap_busy = busy;
    snap_done = done;
    snap_mask = fail_mask;
    snap_meas = measured_half;
    snap_ok   = clk_ok;
    timed_out = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (stim !== last) begin
        last = stim;
        seq.push_back(stim);
      end
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      start = (c == mid_start_at);
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (stim !== 4'b1111) begin
      failures++;
      $display("FAIL reset_stim: got %b expected 1111", stim);
    end
    checks++;
    if ({busy, done, pass, clk_ok} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags: got busy/done/pass/clk_ok=%b expected 0000",
               {busy, done, pass, clk_ok});
    end
    checks++;
    if (fail_mask !== 4'b0000 || measured_half !== 10'd0) begin
      failures++;
      $display("FAIL reset_results: got mask=%b meas=%0d expected 0000/0",
               fail_mask, measured_half);
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_wins_over_start: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_ideal();
    int cyc;
    bit to;
    fault_mode = 0;
    sck_half = EH;
    sck_run = 1'b1;
    run_once(-1, cyc, to);
    checks++;
    if (to) begin
      failures++;
      $display("FAIL ideal_done: done not seen within budget");
    end
    checks++;
    if ({done, pass, clk_ok, busy} !== 4'b1110) begin
      failures++;
      $display("FAIL ideal_flags: got done/pass/clk_ok/busy=%b expected 1110",
               {done, pass, clk_ok, busy});
    end
    checks++;
    if (fail_mask !== 4'b0000 || measured_half !== 10'(EH)) begin
      failures++;
      $display("FAIL ideal_results: got mask=%b meas=%0d expected 0000/%0d",
               fail_mask, measured_half, EH);
    end
    checks++;
    if (!seq_ok()) begin
      failures++;
      $display("FAIL ideal_stim_seq: got %0d distinct values, expected %0d in walk order",
               seq.size(), N + 2);
    end
    checks++;
    if (cyc < (N + 1) * S + EH || cyc > (N + 1) * S + 2 * EH + 4) begin
      failures++;
      $display("FAIL ideal_length: got %0d cycles expected %0d..%0d",
               cyc, (N + 1) * S + EH, (N + 1) * S + 2 * EH + 4);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done !== 1'b1 || stim !== 4'b1111) begin
      failures++;
      $display("FAIL done_holds: got done=%b stim=%b expected 1/1111", done, stim);
    end
  endtask

  task automatic test_stuck();
    int cyc;
    bit to;
    logic [N-1:0] em;
    for (int k = 0; k < 3; k++) begin
      fault_mode = 1;
      fault_a = (k == 0) ? 2 : int'($urandom_range(0, N - 1));
      em = exp_mask(1, fault_a, 0);
      run_once(-1, cyc, to);
      checks++;
      if (to || fail_mask !== em || pass !== 1'b0 || clk_ok !== 1'b1) begin
        failures++;
        $display("FAIL stuck_bit%0d: got to=%b mask=%b pass=%b clk_ok=%b expected 0/%b/0/1",
                 fault_a, to, fail_mask, pass, clk_ok, em);
      end
    end
    fault_mode = 0;
  endtask

  task automatic test_short();
    int cyc;
    bit to;
    logic [N-1:0] em;
    for (int k = 0; k < 3; k++) begin
      fault_mode = 2;
      if (k == 0) begin
        fault_a = 1;
        fault_b = 3;
      end else begin
        fault_a = int'($urandom_range(0, N - 1));
        fault_b = (fault_a + int'($urandom_range(1, N - 1))) % N;
      end
      em = exp_mask(2, fault_a, fault_b);
      run_once(-1, cyc, to);
      checks++;
      if (to || fail_mask !== em || pass !== 1'b0) begin
        failures++;
        $display("FAIL short_%0d_%0d: got to=%b mask=%b pass=%b expected 0/%b/0",
                 fault_a, fault_b, to, fail_mask, pass, em);
      end
    end
    fault_mode = 0;
  endtask

  task automatic test_clock();
    int halves[6];
    int cyc;
    bit to;
    bit eo;
    halves = '{105, 102, 98, 97, 103, 0};
    halves[5] = int'($urandom_range(90, 110));
    fault_mode = 0;
    for (int k = 0; k < 6; k++) begin
      sck_half = halves[k];
      repeat (3 * 110) @(negedge clk);
      eo = exp_clk_ok(halves[k]);
      run_once(-1, cyc, to);
      checks++;
      if (to || measured_half !== 10'(halves[k]) || clk_ok !== eo || pass !== eo ||
          fail_mask !== 4'b0000) begin
        failures++;
        $display("FAIL clk_half_%0d: got to=%b meas=%0d clk_ok=%b pass=%b mask=%b expected 0/%0d/%b/%b/0000",
                 halves[k], to, measured_half, clk_ok, pass, fail_mask, halves[k], eo, eo);
      end
    end
    sck_half = EH;
  endtask

  task automatic test_timeout();
    int cyc;
    bit to;
    sck_run = 1'b0;
    repeat (5) @(negedge clk);
    run_once(-1, cyc, to);
    checks++;
    if (to || done !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_done: got to=%b done=%b busy=%b expected 0/1/0", to, done, busy);
    end
    checks++;
    if (measured_half !== 10'd0 || clk_ok !== 1'b0 || pass !== 1'b0) begin
      failures++;
      $display("FAIL timeout_results: got meas=%0d clk_ok=%b pass=%b expected 0/0/0",
               measured_half, clk_ok, pass);
    end
    checks++;
    if (cyc < (N + 1) * S + 2 * EH || cyc > (N + 1) * S + 2 * EH + 3) begin
      failures++;
      $display("FAIL timeout_length: got %0d cycles expected %0d..%0d",
               cyc, (N + 1) * S + 2 * EH, (N + 1) * S + 2 * EH + 3);
    end
    sck_run = 1'b1;
  endtask

  task automatic test_reset_mid_walk();
    bit found;
    fault_mode = 1;
    fault_a = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (stim === 4'b1011) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found || fail_mask !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL walk_step2_reached: got found=%b mask=%b busy=%b expected 1/0001/1",
               found, fail_mask, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (stim !== 4'b1111 || busy !== 1'b0 || done !== 1'b0 || fail_mask !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_walk: got stim=%b busy=%b done=%b mask=%b expected 1111/0/0/0000",
               stim, busy, done, fail_mask);
    end
    fault_mode = 0;
  endtask

  task automatic test_rerun();
    int cyc;
    bit to;
    fault_mode = 1;
    fault_a = 3;
    run_once(-1, cyc, to);
    checks++;
    if (to || fail_mask !== 4'b1000 || pass !== 1'b0) begin
      failures++;
      $display("FAIL rerun_first: got to=%b mask=%b pass=%b expected 0/1000/0",
               to, fail_mask, pass);
    end
    fault_mode = 0;
    run_once(20, cyc, to);
    checks++;
    if (snap_busy !== 1'b1 || snap_done !== 1'b0 || snap_mask !== 4'b0000 ||
        snap_meas !== 10'd0 || snap_ok !== 1'b0) begin
      failures++;
      $display("FAIL rerun_clears: got busy=%b done=%b mask=%b meas=%0d clk_ok=%b expected 1/0/0000/0/0",
               snap_busy, snap_done, snap_mask, snap_meas, snap_ok);
    end
    checks++;
    if (!seq_ok()) begin
      failures++;
      $display("FAIL start_while_busy_seq: got %0d distinct stim values, expected %0d",
               seq.size(), N + 2);
    end
    checks++;
    if (to || pass !== 1'b1 || fail_mask !== 4'b0000 || measured_half !== 10'(EH)) begin
      failures++;
      $display("FAIL rerun_result: got to=%b pass=%b mask=%b meas=%0d expected 0/1/0000/%0d",
               to, pass, fail_mask, measured_half, EH);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    test_reset();
    test_ideal();
    test_stuck();
    test_short();
    test_clock();
    test_timeout();
    test_reset_mid_walk();
    test_rerun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
